// File: rtl/ad9361_lvds_ctrl_if.sv
// Signal bundle between the AD9361 LVDS controller and its user/I/O side.
// master is the controller end, slave is the I/O block plus sample user.
interface ad9361_lvds_ctrl_if;
    logic        resync;
    logic        clk_reset;
    logic        io_reset;
    logic [13:0] rx_ddr;
    logic [13:0] tx_ddr;
    logic [11:0] rx_i;
    logic [11:0] rx_q;
    logic        rx_valid;
    logic        tx_en;
    logic [11:0] tx_i;
    logic [11:0] tx_q;
    logic        tx_ready;
    logic        locked;
    logic        frame_err;

    modport master (
        input  resync, rx_ddr, tx_en, tx_i, tx_q,
        output clk_reset, io_reset, tx_ddr,
        output rx_i, rx_q, rx_valid, tx_ready,
        output locked, frame_err
    );

    modport slave (
        output resync, rx_ddr, tx_en, tx_i, tx_q,
        input  clk_reset, io_reset, tx_ddr,
        input  rx_i, rx_q, rx_valid, tx_ready,
        input  locked, frame_err
    );
endinterface

// File: rtl/ad9361_lvds_ctrl.sv
// AD9361 1R1T LVDS DDR controller: I/O reset sequencing, RX frame
// alignment with edge-swap recovery, RX unpack and TX pack.
module ad9361_lvds_ctrl #(
    parameter int RST_HOLD = 32,
    parameter int IO_DLY   = 8,
    parameter int LOCK_CNT = 16,
    parameter int ERR_MAX  = 4
) (
    input logic clk,
    input logic rst_n,
    ad9361_lvds_ctrl_if.master bus
);
    localparam int RW = $clog2(RST_HOLD + IO_DLY + 1);
    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int EW = $clog2(ERR_MAX + 1);

    typedef enum logic [1:0] {
        RST_SEQ = 2'd0,
        SEARCH  = 2'd1,
        LOCKED  = 2'd2
    } state_e;

    state_e      state_q;
    logic [RW-1:0] rcnt_q;
    logic [GW-1:0] good_q, good_d;
    logic [EW-1:0] err_q, err_d;
    logic        sw_q, pf_q, pfn_q;
    logic [5:0]  pn_q, ai_q, aq_q;
    logic        a_ok_q;
    logic        clk_rst_q, io_rst_q;
    logic [13:0] tx_ddr_q;
    logic [11:0] tx_lo_q;
    logic        tx_rdy_q;
    logic [11:0] rx_i_q, rx_q_q;
    logic        rx_vld_q, locked_q, ferr_q;

    logic [5:0]  pos, neg, p_d, n_d;
    logic        fp, fn, fa, fb, pair_ok;

    assign pos = bus.rx_ddr[5:0];
    assign fp  = bus.rx_ddr[6];
    assign neg = bus.rx_ddr[12:7];
    assign fn  = bus.rx_ddr[13];

    // sw=1 rebuilds the pair from last cycle's negedge and this posedge
    always_comb begin
        p_d = sw_q ? pn_q  : pos;
        n_d = sw_q ? pos   : neg;
        fa  = sw_q ? pfn_q : fp;
        fb  = sw_q ? fp    : fn;
        pair_ok = (fa == fb) && (fa != pf_q);
        good_d = good_q + GW'(1);
        err_d  = err_q + EW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_SEQ;
            rcnt_q    <= '0;
            good_q    <= '0;
            err_q     <= '0;
            sw_q      <= 1'b0;
            pf_q      <= 1'b0;
            pfn_q     <= 1'b0;
            pn_q      <= '0;
            ai_q      <= '0;
            aq_q      <= '0;
            a_ok_q    <= 1'b0;
            clk_rst_q <= 1'b1;
            io_rst_q  <= 1'b1;
            tx_ddr_q  <= '0;
            tx_lo_q   <= '0;
            tx_rdy_q  <= 1'b0;
            rx_i_q    <= '0;
            rx_q_q    <= '0;
            rx_vld_q  <= 1'b0;
            locked_q  <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            pn_q     <= neg;
            pfn_q    <= fn;
            rx_vld_q <= 1'b0;
            ferr_q   <= 1'b0;
            if (bus.resync) begin
                state_q   <= RST_SEQ;
                rcnt_q    <= '0;
                good_q    <= '0;
                err_q     <= '0;
                a_ok_q    <= 1'b0;
                clk_rst_q <= 1'b1;
                io_rst_q  <= 1'b1;
                tx_ddr_q  <= '0;
                tx_lo_q   <= '0;
                tx_rdy_q  <= 1'b0;
                locked_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    RST_SEQ: begin
                        rcnt_q   <= rcnt_q + RW'(1);
                        a_ok_q   <= 1'b0;
                        tx_ddr_q <= '0;
                        tx_lo_q  <= '0;
                        tx_rdy_q <= 1'b0;
                        if (rcnt_q == RW'(RST_HOLD - 1))
                            clk_rst_q <= 1'b0;
                        if (rcnt_q == RW'(RST_HOLD + IO_DLY - 1)) begin
                            io_rst_q <= 1'b0;
                            state_q  <= SEARCH;
                        end
                    end
                    SEARCH: begin
                        if (fa != fb) begin
                            sw_q   <= ~sw_q;
                            good_q <= '0;
                        end else begin
                            pf_q <= fa;
                            if (!pair_ok) begin
                                good_q <= '0;
                            end else if (good_d == GW'(LOCK_CNT)) begin
                                good_q   <= '0;
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end else begin
                                good_q <= good_d;
                            end
                        end
                    end
                    LOCKED: begin
                        // expected frame phase free-runs once aligned
                        pf_q <= ~pf_q;
                        if (pair_ok) begin
                            err_q <= '0;
                        end else begin
                            ferr_q <= 1'b1;
                            if (err_d == EW'(ERR_MAX)) begin
                                err_q    <= '0;
                                good_q   <= '0;
                                state_q  <= SEARCH;
                                locked_q <= 1'b0;
                            end else begin
                                err_q <= err_d;
                            end
                        end
                    end
                    default: state_q <= RST_SEQ;
                endcase

                if (state_q != RST_SEQ) begin
                    if (!pair_ok) begin
                        a_ok_q <= 1'b0;
                    end else if (fa) begin
                        ai_q   <= p_d;
                        aq_q   <= n_d;
                        a_ok_q <= 1'b1;
                    end else begin
                        a_ok_q <= 1'b0;
                        if (a_ok_q) begin
                            rx_i_q   <= {ai_q, p_d};
                            rx_q_q   <= {aq_q, n_d};
                            rx_vld_q <= (state_q == LOCKED);
                        end
                    end

                    if (tx_rdy_q) begin
                        tx_rdy_q <= 1'b0;
                        if (bus.tx_en) begin
                            tx_ddr_q <= {1'b1, bus.tx_q[11:6],
                                         1'b1, bus.tx_i[11:6]};
                            tx_lo_q  <= {bus.tx_q[5:0], bus.tx_i[5:0]};
                        end else begin
                            tx_ddr_q <= 14'h2040;
                            tx_lo_q  <= '0;
                        end
                    end else begin
                        tx_rdy_q <= 1'b1;
                        tx_ddr_q <= {1'b0, tx_lo_q[11:6],
                                     1'b0, tx_lo_q[5:0]};
                    end
                end
            end
        end
    end

    assign bus.clk_reset = clk_rst_q;
    assign bus.io_reset  = io_rst_q;
    assign bus.tx_ddr    = tx_ddr_q;
    assign bus.tx_ready  = tx_rdy_q;
    assign bus.rx_i      = rx_i_q;
    assign bus.rx_q      = rx_q_q;
    assign bus.rx_valid  = rx_vld_q;
    assign bus.locked    = locked_q;
    assign bus.frame_err = ferr_q;
endmodule

// File: tb/tb_ad9361_lvds_ctrl.sv
// Directed loopback bench for ad9361_lvds_ctrl: reset sequence, aligned
// and half-cycle-skewed RX, frame glitches, TX zero fill and resync.
module tb_ad9361_lvds_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ad9361_lvds_ctrl_if bus();

    ad9361_lvds_ctrl #(
        .RST_HOLD(32), .IO_DLY(8), .LOCK_CNT(16), .ERR_MAX(4)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    logic        skew = 1'b0;
    logic [13:0] glitch = '0;
    logic [13:0] prev_tx = '0;
    logic [13:0] rx_sk;
    always @(posedge clk) prev_tx <= bus.tx_ddr;
    // RX stream late by one DDR edge
    assign rx_sk = {bus.tx_ddr[6], bus.tx_ddr[5:0],
                    prev_tx[13], prev_tx[12:7]};
    assign bus.rx_ddr = (skew ? rx_sk : bus.tx_ddr) ^ glitch;

    int n_tot = 0;
    int n_bad = 0;
    logic rx_chk_en = 1'b0;
    int exp_i = 0;
    int exp_q = 0;

    task automatic chk(input string tag, input int got, input int exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk)
        if (rx_chk_en && bus.rx_valid) begin
            chk("rx_i", 32'(bus.rx_i), exp_i);
            chk("rx_q", 32'(bus.rx_q), exp_q);
        end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_lock(input int max, output int n);
        n = 0;
        while (!bus.locked && n < max) begin
            step();
            n++;
        end
    endtask

    task automatic wait_rdy();
        int k = 0;
        while (!bus.tx_ready && k < 8) begin
            step();
            k++;
        end
        chk("rdy_seen", 32'(bus.tx_ready), 1);
    endtask

    task automatic lat_chk(input int lat);
        wait_rdy();
        repeat (lat - 1) step();
        chk("lat_pre", 32'(bus.rx_valid), 0);
        step();
        chk("lat_hit", 32'(bus.rx_valid), 1);
    endtask

    task automatic cnt_valid(input string tag);
        int nv = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            nv += int'(bus.rx_valid);
        end
        chk(tag, nv, 20);
    endtask

    initial begin
        int cr_fall, io_fall, n, ne;
        logic [13:0] txor;
        bus.resync = 1'b0;
        bus.tx_en  = 1'b1;
        bus.tx_i   = 12'hABC;
        bus.tx_q   = 12'h123;
        exp_i = 32'h0ABC;
        exp_q = 32'h0123;

        repeat (3) step();
        chk("rst_clk_reset", 32'(bus.clk_reset), 1);
        chk("rst_io_reset", 32'(bus.io_reset), 1);
        chk("rst_tx_ddr", 32'(bus.tx_ddr), 0);
        chk("rst_outs", 32'({bus.locked, bus.rx_valid,
                             bus.tx_ready, bus.frame_err}), 0);
        chk("rst_rx", 32'({bus.rx_i, bus.rx_q}), 0);

        @(negedge clk) rst_n = 1'b1;
        cr_fall = 0;
        io_fall = 0;
        txor = '0;
        for (int i = 1; i <= 45; i++) begin
            step();
            if (!bus.clk_reset && cr_fall == 0) cr_fall = i;
            if (!bus.io_reset && io_fall == 0) io_fall = i;
            if (i <= 40) txor |= bus.tx_ddr;
        end
        chk("clk_reset_fall", cr_fall, 32);
        chk("io_reset_fall", io_fall, 40);
        chk("seq_tx_zero", 32'(txor), 0);

        wait_lock(100, n);
        chk("lock_aln", 32'(bus.locked), 1);
        chk("sw_aln", 32'(dut.sw_q), 0);

        wait_rdy();
        step();
        chk("tx_A", 32'(bus.tx_ddr), 32'h226A);
        step();
        chk("tx_B", 32'(bus.tx_ddr), 32'h11BC);

        rx_chk_en = 1'b1;
        lat_chk(3);
        cnt_valid("vcnt_aln");

        @(negedge clk) glitch = 14'h0040;
        ne = 0;
        repeat (3) begin
            step();
            ne += int'(bus.frame_err);
        end
        @(negedge clk) glitch = '0;
        chk("ferr3", ne, 3);
        chk("lock_hold", 32'(bus.locked), 1);

        repeat (10) step();
        @(negedge clk) glitch = 14'h0040;
        ne = 0;
        repeat (4) begin
            step();
            ne += int'(bus.frame_err);
        end
        @(negedge clk) glitch = '0;
        chk("ferr4", ne, 4);
        chk("unlock", 32'(bus.locked), 0);
        wait_lock(40, n);
        chk("relock", 32'(bus.locked), 1);

        rx_chk_en = 1'b0;
        @(negedge clk) bus.tx_en = 1'b0;
        wait_rdy();
        step();
        chk("txz_A", 32'(bus.tx_ddr), 32'h2040);
        step();
        chk("txz_B", 32'(bus.tx_ddr), 0);
        @(negedge clk) bus.tx_en = 1'b1;

        repeat (6) step();
        @(negedge clk) bus.resync = 1'b1;
        step();
        chk("rsy_locked", 32'(bus.locked), 0);
        chk("rsy_resets", 32'({bus.clk_reset, bus.io_reset}), 3);
        chk("rsy_tx", 32'({bus.tx_ready, bus.tx_ddr}), 0);
        @(negedge clk) bus.resync = 1'b0;
        wait_lock(80, n);
        chk("rsy_relock", 32'(bus.locked), 1);
        chk("rsy_cycles", 32'(n + 1 <= 60), 1);

        @(negedge clk) rst_n = 1'b0;
        skew = 1'b1;
        bus.tx_i = 12'h5A3;
        bus.tx_q = 12'hE71;
        exp_i = 32'h05A3;
        exp_q = 32'h0E71;
        repeat (2) step();
        @(negedge clk) rst_n = 1'b1;
        wait_lock(150, n);
        chk("lock_skew", 32'(bus.locked), 1);
        chk("sw_skew", 32'(dut.sw_q), 1);
        rx_chk_en = 1'b1;
        lat_chk(4);
        cnt_valid("vcnt_skew");
        rx_chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
